// File: rtl/ipg_tx_serializer.sv
// IPG TX serializer: queues IPG reply messages, emits them MSB-first.
// Each chunk is MSB-aligned in a 64-bit word; its bit count is on tx_len.
//
// Ports:
//   clk, rst_n       clock, async active-low reset
//   msg_data/valid   message in; msg_ready = FIFO has room
//   slot_len         IPG bits granted for the next TX block (0..63)
//   tx_ipg_data      chunk in [63 -: tx_len], other bits 0
//   tx_len           chunk length, 0..MAX_SLOT
//   tx_msg_start     first non-empty chunk of a message
//   tx_msg_last      chunk that completes a message
//   fifo_count       queued messages (excludes the one in flight)
//   busy             a message is in the shift register
// MSG_WIDTH must be at least 64.
module ipg_tx_serializer #(
  parameter int MSG_WIDTH  = 520,
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_SLOT   = 56
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [MSG_WIDTH-1:0]          msg_data,
  input  logic                          msg_valid,
  output logic                          msg_ready,
  input  logic [5:0]                    slot_len,
  output logic [63:0]                   tx_ipg_data,
  output logic [5:0]                    tx_len,
  output logic                          tx_msg_start,
  output logic                          tx_msg_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = $clog2(MSG_WIDTH + 1);

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_t;

  logic [MSG_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_q, wr_d;
  logic [PW-1:0]        rd_q, rd_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  state_t               state_q, state_d;
  logic [MSG_WIDTH-1:0] sr_q, sr_d;
  logic [RW-1:0]        rem_q, rem_d;

  logic [63:0]          data_q, data_d;
  logic [5:0]           len_q, len_d;
  logic                 start_q, start_d;
  logic                 last_q, last_d;

  logic                 push, pop;
  logic [5:0]           eff, grant;
  logic [63:0]          top, mask;

  // Gated by rst_n so nothing is offered while held in reset.
  assign msg_ready = rst_n && (cnt_q < CW'(FIFO_DEPTH));
  assign push      = msg_valid && msg_ready;
  assign pop       = (state_q == S_IDLE) && (cnt_q != '0);

  assign wr_d  = wr_q + PW'(push);
  assign rd_d  = rd_q + PW'(pop);
  assign cnt_d = cnt_q + CW'(push) - CW'(pop);

  // Shift register stays left-aligned: the next bits are always on top.
  assign eff   = (slot_len > 6'(MAX_SLOT)) ? 6'(MAX_SLOT) : slot_len;
  assign grant = (RW'(eff) < rem_q) ? eff : 6'(rem_q);
  assign top   = sr_q[MSG_WIDTH-1 -: 64];
  assign mask  = ~({64{1'b1}} >> grant);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    rem_d   = rem_q;
    data_d  = '0;
    len_d   = '0;
    start_d = 1'b0;
    last_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          sr_d    = mem_q[rd_q];
          rem_d   = RW'(MSG_WIDTH);
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (grant != '0) begin
          data_d  = top & mask;
          len_d   = grant;
          start_d = (rem_q == RW'(MSG_WIDTH));
          last_d  = (RW'(grant) == rem_q);
          sr_d    = sr_q << grant;
          rem_d   = rem_q - RW'(grant);
          if (last_d) state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= msg_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      state_q <= S_IDLE;
      sr_q    <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      len_q   <= '0;
      start_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      sr_q    <= sr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      len_q   <= len_d;
      start_q <= start_d;
      last_q  <= last_d;
    end
  end

  assign tx_ipg_data  = data_q;
  assign tx_len       = len_q;
  assign tx_msg_start = start_q;
  assign tx_msg_last  = last_q;
  assign fifo_count   = cnt_q;
  assign busy         = (state_q == S_SEND);

endmodule

// File: doc/ipg_tx_serializer.md
Name: ipg_tx_serializer

Overview:
- Downstream TX stage after the IPG processor.
- Accepts complete IPG reply messages (520 bits), queues them in a small message FIFO, and drains them MSB-first into the per-cycle IPG bit budget granted by the PCS transmit path.
- Output format matches the RX side:
  - data is MSB-aligned in a 64-bit word;
  - the valid bit count is given on a 6-bit length.

Parameters:
- MSG_WIDTH, 520, bits per message.
- FIFO_DEPTH, 2, message FIFO entries; must be a power of 2, minimum 2.
- MAX_SLOT, 56, maximum bits emitted per cycle; slot requests above this are clamped.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- msg_data  input  MSG_WIDTH  message to enqueue; bit MSG_WIDTH-1 is sent first.
- msg_valid  input  1  msg_data is valid.
- msg_ready  output  1  FIFO can accept a message.
- slot_len  input  6  IPG bits available in the next TX block, 0..63.
- tx_ipg_data  output  64  emitted bits in [63 -: tx_len]; all other bits are 0.
- tx_len  output  6  number of valid bits in tx_ipg_data, 0..MAX_SLOT.
- tx_msg_start  output  1  current chunk is the first chunk of a message.
- tx_msg_last  output  1  current chunk completes a message.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  messages waiting in the FIFO (excludes the message being sent).
- busy  output  1  a message is loaded in the shift register.

Behaviour:
- Reset (asynchronous on rst_n low):
  - tx_ipg_data=0, tx_len=0, tx_msg_start=0, tx_msg_last=0, busy=0, fifo_count=0;
  - FIFO pointers cleared; state=IDLE; remaining=0.
  - msg_ready is 1 once rst_n is high.
- msg_ready = (fifo_count < FIFO_DEPTH), decoded combinationally from the registered count.
  - Push occurs when msg_valid && msg_ready at a clock edge.
  - msg_valid while msg_ready=0 is ignored; no overwrite.
- FIFO pop occurs only in IDLE when fifo_count > 0.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - A push into an empty FIFO cannot be popped in the same cycle (one-cycle FIFO latency).
- State IDLE:
  - If fifo_count > 0: load the head into the MSG_WIDTH shift register, set remaining=MSG_WIDTH, set busy=1, go to SEND.
  - In every IDLE cycle, tx_len=0 and tx_ipg_data=0 regardless of slot_len.
- State SEND, each cycle:
  - eff = min(slot_len, MAX_SLOT); grant = min(eff, remaining).
  - On the next edge: tx_ipg_data[63 -: grant] = msg[remaining-1 -: grant]; lower bits = 0; tx_len = grant; remaining -= grant.
  - Latency: slot_len sampled at edge N appears on tx_* after edge N.
- slot_len=0 in SEND gives tx_len=0 with no state change. Flags stay 0 for zero-length cycles.
- tx_msg_start=1 on the first chunk with grant>0 of each message.
- tx_msg_last=1 on the chunk where remaining becomes 0. That cycle: busy clears, state returns to IDLE.
  - A single chunk can carry both flags only if MSG_WIDTH <= MAX_SLOT.
- Back-to-back messages: exactly one IDLE (zero-length) cycle separates the last chunk of message k from any chunk of message k+1.
- Width rules:
  - remaining is $clog2(MSG_WIDTH+1) bits and never underflows.
  - Chunk extraction uses a variable part-select on the shift register, or an equivalent left shift by grant.
- With default parameters, a message at full 56-bit slots takes 10 chunks: 9×56 followed by 16.
- Reset mid-message: the message is dropped, the FIFO is flushed, and outputs are zero. Transmission restarts cleanly from bit MSG_WIDTH-1 of the next message pushed.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately; msg_ready=1 after release.
- Single message, slot_len held at 56:
  - Stimulus: msg_data with bits [i+:16]=i for i=0,16,...,512.
  - Required: 10 non-zero chunks; chunk 1 = msg[519:464] with tx_msg_start=1; chunks 1-9 have tx_len=56; chunk 10 has tx_len=16 with data msg[15:0] in [63:48] and tx_msg_last=1; busy=0 afterwards.
- Slot variation in SEND, slot_len sequence 0, 8, 60, 3:
  - tx_len sequence 0, 8, 56, 3.
  - Bits are contiguous MSB-first; the 0 cycle advances nothing; remaining goes 520→512→456→453.
- FIFO full, slot_len=0:
  - Push A, B, C back-to-back -> A is loaded (busy=1), fifo_count=2, msg_ready=0; a D offered with msg_valid=1 is not accepted.
  - Set slot_len=56 -> A drains; B is popped one cycle after A's tx_msg_last; msg_ready=1 that cycle; D is accepted.
- Reset mid-message: assert rst_n low after 3 chunks of A (remaining=352) -> outputs 0, fifo_count=0; after a new push, the first chunk again equals msg[519:464].
- Simultaneous push/pop: push a message in the same cycle IDLE pops the only queued entry -> fifo_count stays 1; no message is lost or duplicated (checked by a scoreboard comparing emitted bitstream to pushed messages).
